// File: rtl/top.sv
// Single-cycle RV32-style datapath: PC, immediate generator, register file, ALU and data memory.
// Control arrives on ports; the instruction is supplied externally each cycle.
module top #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        PCSrc_in,
    input  logic [1:0]  immSrc_in,
    input  logic        ALUSrc_in,
    input  logic [1:0]  alu_op_in,
    input  logic        MemWrite_in,
    input  logic        RegWrite_in,
    input  logic        MemToReg_in,
    input  logic [31:0] instr_in
);

    localparam int unsigned MemDepth = 1 << ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] PC;
    logic [31:0]           instr;
    logic [DATA_WIDTH-1:0] ALUResult;
    logic [DATA_WIDTH-1:0] ReadData;
    logic                  RegWrite;
    logic                  MemWrite;

    logic [31:0]           imm32;
    logic [DATA_WIDTH-1:0] imm_ext;
    logic [DATA_WIDTH-1:0] src_a;
    logic [DATA_WIDTH-1:0] src_b;
    logic [DATA_WIDTH-1:0] rd2_data;
    logic [DATA_WIDTH-1:0] wb_data;
    logic [4:0]            rs1;
    logic [4:0]            rs2;
    logic [4:0]            rd;
    logic [2:0]            funct3;
    logic [ADDR_WIDTH-1:0] mem_idx;

    logic [DATA_WIDTH-1:0] regs [32];
    logic [DATA_WIDTH-1:0] mem  [MemDepth] = '{default: '0};

    assign instr    = instr_in;
    assign RegWrite = RegWrite_in;
    assign MemWrite = MemWrite_in;

    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];

    always_comb begin
        imm32 = '0;
        case (immSrc_in)
            2'b00: imm32 = {{20{instr[31]}}, instr[31:20]};
            2'b01: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            2'b10: imm32 = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
            2'b11: imm32 = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm_ext = DATA_WIDTH'($signed(imm32));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            PC <= '0;
        end else if (PCSrc_in) begin
            PC <= PC + imm_ext;
        end else begin
            PC <= PC + DATA_WIDTH'(4);
        end
    end

    // x0 is never written, so regs[0] stays zero after reset; the mux keeps it zero before too.
    assign src_a    = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rd2_data = (rs2 == 5'd0) ? '0 : regs[rs2];
    assign src_b    = ALUSrc_in ? imm_ext : rd2_data;

    always_comb begin
        ALUResult = src_a + src_b;
        case (alu_op_in)
            2'b00: ALUResult = src_a + src_b;
            2'b01: ALUResult = src_a - src_b;
            2'b10: begin
                case (funct3)
                    3'b000:  ALUResult = (instr[30] && instr[5]) ? (src_a - src_b)
                                                                  : (src_a + src_b);
                    3'b010:  ALUResult = DATA_WIDTH'($signed(src_a) < $signed(src_b));
                    3'b110:  ALUResult = src_a | src_b;
                    3'b111:  ALUResult = src_a & src_b;
                    default: ALUResult = src_a + src_b;
                endcase
            end
            2'b11: ALUResult = src_b;
            default: ALUResult = src_a + src_b;
        endcase
    end

    assign mem_idx  = ALUResult[ADDR_WIDTH+1:2];
    assign ReadData = mem[mem_idx];
    assign wb_data  = MemToReg_in ? ReadData : ALUResult;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                regs[i] <= '0;
            end
        end else if (RegWrite_in && (rd != 5'd0)) begin
            regs[rd] <= wb_data;
        end
    end

    // Memory contents survive reset; rst only gates the write.
    always_ff @(posedge clk) begin
        if (rst && MemWrite_in) begin
            mem[mem_idx] <= rd2_data;
        end
    end

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the single-cycle datapath: expectations are queued at stimulus time
// and compared against hierarchical DUT state once the corresponding point is reached.
module tb_top;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        PCSrc_in = 1'b0;
    logic [1:0]  immSrc_in = 2'b00;
    logic        ALUSrc_in = 1'b0;
    logic [1:0]  alu_op_in = 2'b00;
    logic        MemWrite_in = 1'b0;
    logic        RegWrite_in = 1'b0;
    logic        MemToReg_in = 1'b0;
    logic [31:0] instr_in = 32'h0;

    int n_checks = 0;
    int n_pass   = 0;

    localparam int SelPc = 0, SelReg = 1, SelMem = 2, SelAlu = 3, SelRd = 4;

    typedef struct {
        string       tag;
        int          sel;
        int          idx;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];

    top #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PCSrc_in   (PCSrc_in),
        .immSrc_in  (immSrc_in),
        .ALUSrc_in  (ALUSrc_in),
        .alu_op_in  (alu_op_in),
        .MemWrite_in(MemWrite_in),
        .RegWrite_in(RegWrite_in),
        .MemToReg_in(MemToReg_in),
        .instr_in   (instr_in)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h required %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observe(input int sel, input int idx);
        case (sel)
            SelPc:   return dut.PC;
            SelReg:  return dut.regs[idx];
            SelMem:  return dut.mem[idx];
            SelAlu:  return dut.ALUResult;
            default: return dut.ReadData;
        endcase
    endfunction

    task automatic expect_val(input string tag, input int sel, input int idx,
                              input logic [31:0] exp);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.idx = idx;
        e.exp = exp;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t e;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.tag, observe(e.sel, e.idx), e.exp);
        end
    endtask

    // Apply one instruction with its control word at the falling edge.
    task automatic drive(input logic [31:0] ins, input logic pcsrc, input logic [1:0] imm,
                         input logic alusrc, input logic [1:0] op, input logic mw,
                         input logic rw, input logic m2r);
        @(negedge clk);
        instr_in    = ins;
        PCSrc_in    = pcsrc;
        immSrc_in   = imm;
        ALUSrc_in   = alusrc;
        alu_op_in   = op;
        MemWrite_in = mw;
        RegWrite_in = rw;
        MemToReg_in = m2r;
    endtask

    task automatic settle();
        #1;
        drain();
    endtask

    task automatic clock_edge();
        @(posedge clk);
        #1;
        drain();
    endtask

    initial begin
        // Reset held low across the first rising edge.
        #8;
        expect_val("rst_pc", SelPc, 0, 32'd0);
        for (int i = 0; i < 32; i++) expect_val($sformatf("rst_x%0d", i), SelReg, i, 32'd0);
        drain();

        @(negedge clk);
        rst = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            expect_val($sformatf("pc_seq%0d", i), SelPc, 0, 32'(4 * i));
            clock_edge();
        end

        // addi x2,x0,5
        drive(32'h00500113, 0, 2'b00, 1, 2'b00, 0, 1, 0);
        expect_val("addi_alu", SelAlu, 0, 32'd5);
        settle();
        expect_val("addi_x2", SelReg, 2, 32'd5);
        expect_val("addi_pc", SelPc, 0, 32'd16);
        clock_edge();

        // addi x4,x0,-3
        drive(32'hFFD00213, 0, 2'b00, 1, 2'b00, 0, 1, 0);
        expect_val("addin_alu", SelAlu, 0, 32'hFFFF_FFFD);
        settle();
        expect_val("addin_x4", SelReg, 4, 32'hFFFF_FFFD);
        clock_edge();

        // sub x5,x2,x4 via funct3 decode
        drive(32'h404102B3, 0, 2'b00, 0, 2'b10, 0, 1, 0);
        expect_val("sub_alu", SelAlu, 0, 32'd8);
        settle();
        expect_val("sub_x5", SelReg, 5, 32'd8);
        clock_edge();

        // slt x6,x4,x2 (-3 < 5 signed)
        drive(32'h00222333, 0, 2'b00, 0, 2'b10, 0, 1, 0);
        expect_val("slt_alu", SelAlu, 0, 32'd1);
        settle();
        expect_val("slt_x6", SelReg, 6, 32'd1);
        clock_edge();

        // sw x2,8(x0)
        drive(32'h00202423, 0, 2'b01, 1, 2'b00, 1, 0, 0);
        expect_val("sw_alu", SelAlu, 0, 32'd8);
        settle();
        expect_val("sw_mem2", SelMem, 2, 32'd5);
        clock_edge();

        // lw x3,8(x0)
        drive(32'h00802183, 0, 2'b00, 1, 2'b00, 0, 1, 1);
        expect_val("lw_rdata", SelRd, 0, 32'd5);
        settle();
        expect_val("lw_x3", SelReg, 3, 32'd5);
        clock_edge();

        // addi x0,x0,5: write discarded
        drive(32'h00500013, 0, 2'b00, 1, 2'b00, 0, 1, 0);
        expect_val("x0_alu", SelAlu, 0, 32'd5);
        settle();
        expect_val("x0_zero", SelReg, 0, 32'd0);
        clock_edge();

        // addi x2,x2,1: operand read sees old value
        drive(32'h00110113, 0, 2'b00, 1, 2'b00, 0, 1, 0);
        expect_val("rmw_alu", SelAlu, 0, 32'd6);
        settle();
        expect_val("rmw_x2", SelReg, 2, 32'd6);
        clock_edge();

        // sw x4,8(x0): same-cycle read returns old word
        drive(32'h00402423, 0, 2'b01, 1, 2'b00, 1, 0, 0);
        expect_val("sw_old_rd", SelRd, 0, 32'd5);
        settle();
        expect_val("sw_new_mem2", SelMem, 2, 32'hFFFF_FFFD);
        clock_edge();

        // and x7,x2,x4
        drive(32'h004173B3, 0, 2'b00, 0, 2'b10, 0, 1, 0);
        expect_val("and_alu", SelAlu, 0, 32'd4);
        settle();
        expect_val("and_x7", SelReg, 7, 32'd4);
        clock_edge();

        // rs1=x2, imm 7: pass-B then plain SUB class
        drive(32'h00710013, 0, 2'b00, 1, 2'b11, 0, 0, 0);
        expect_val("passb_alu", SelAlu, 0, 32'd7);
        settle();
        clock_edge();
        drive(32'h00710013, 0, 2'b00, 1, 2'b01, 0, 0, 0);
        expect_val("subop_alu", SelAlu, 0, 32'hFFFF_FFFF);
        settle();
        expect_val("pc_after_prog", SelPc, 0, 32'd60);
        clock_edge();

        // Asynchronous reset mid-cycle; a pending write must be blocked.
        drive(32'h00500113, 0, 2'b00, 1, 2'b00, 1, 1, 0);
        #2;
        rst = 1'b0;
        #1;
        expect_val("arst_pc", SelPc, 0, 32'd0);
        expect_val("arst_x2", SelReg, 2, 32'd0);
        expect_val("arst_x7", SelReg, 7, 32'd0);
        expect_val("arst_mem_kept", SelMem, 2, 32'hFFFF_FFFD);
        drain();
        expect_val("rst_blk_x2", SelReg, 2, 32'd0);
        expect_val("rst_blk_pc", SelPc, 0, 32'd0);
        expect_val("rst_blk_mem", SelMem, 2, 32'hFFFF_FFFD);
        clock_edge();

        drive(32'h0, 0, 2'b00, 0, 2'b00, 0, 0, 0);
        rst = 1'b1;
        expect_val("rel_pc4", SelPc, 0, 32'd4);
        clock_edge();
        expect_val("rel_pc8", SelPc, 0, 32'd8);
        clock_edge();

        // Branches: +16, -16, -8, then jal +8
        drive(32'h00000863, 1, 2'b10, 0, 2'b01, 0, 0, 0);
        expect_val("br_p16", SelPc, 0, 32'd24);
        clock_edge();
        drive(32'hFE0008E3, 1, 2'b10, 0, 2'b01, 0, 0, 0);
        expect_val("br_m16", SelPc, 0, 32'd8);
        clock_edge();
        drive(32'hFE000CE3, 1, 2'b10, 0, 2'b01, 0, 0, 0);
        expect_val("br_m8", SelPc, 0, 32'd0);
        clock_edge();
        drive(32'h0080006F, 1, 2'b11, 0, 2'b00, 0, 0, 0);
        expect_val("jal_p8", SelPc, 0, 32'd8);
        clock_edge();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
